// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: scheduler state encodings and
// default speed-scheduler constants.
package dino_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE   = 2'd0,
        SCHED_RUN    = 2'd1,
        SCHED_FROZEN = 2'd2
    } sched_state_t;

    localparam int unsigned DEF_ACC_W     = 8;
    localparam logic [9:0]  DEF_BASE_INC  = 10'd256;
    localparam logic [9:0]  DEF_INC_STEP  = 10'd32;
    localparam logic [3:0]  DEF_MAX_LEVEL = 4'd15;

endpackage

// File: rtl/step_burst.sv
// Pending-step counter: loads 0..3 steps per tick, saturates at 7, and
// drains one step per cycle as a step pulse.
module step_burst (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [1:0] i_k,
    output logic       o_step_pulse
);

    logic [2:0] r_pending;
    logic [2:0] w_base;
    logic [3:0] w_loaded;
    logic [2:0] w_next;

    // A load on a draining cycle adds onto the already-decremented count.
    assign w_base   = (r_pending != '0) ? (r_pending - 3'd1) : '0;
    assign w_loaded = {1'b0, w_base} + {2'b00, i_k};

    always_comb begin
        w_next = w_base;
        if (i_clear) begin
            w_next = '0;
        end else if (i_load) begin
            w_next = w_loaded[3] ? 3'd7 : w_loaded[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    assign o_step_pulse = (r_pending != '0);

endmodule

// File: rtl/speed_scheduler.sv
// Difficulty-driven scroll speed: level tracks score hundreds, a phase
// accumulator turns the level into a burst of step pulses per game tick.
module speed_scheduler
    import dino_pkg::*;
#(
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter logic [9:0]  BASE_INC  = DEF_BASE_INC,
    parameter logic [9:0]  INC_STEP  = DEF_INC_STEP,
    parameter logic [3:0]  MAX_LEVEL = DEF_MAX_LEVEL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_tick,
    input  logic        game_start,
    input  logic        game_frozen,
    input  logic [15:0] score,
    output logic        step_pulse,
    output logic        busy,
    output logic [3:0]  level,
    output logic [1:0]  state
);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [3:0]       r_level;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_score_hi_prev;

    logic [9:0]       w_inc;
    logic [ACC_W+1:0] w_sum;
    logic [1:0]       w_k;
    logic             w_tick_fire;
    logic             w_clear;
    logic             w_step;

    assign w_inc       = BASE_INC + 10'(r_level) * INC_STEP;
    assign w_sum       = {2'b00, r_acc} + (ACC_W+2)'(w_inc);
    assign w_k         = w_sum[ACC_W+1:ACC_W];
    assign w_tick_fire = game_tick && (r_state == SCHED_RUN) && !game_frozen && !game_start;
    assign w_clear     = game_start || game_frozen;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCHED_IDLE: begin
                if (game_start) w_state_next = SCHED_RUN;
            end
            SCHED_RUN: begin
                if (game_start)       w_state_next = SCHED_RUN;
                else if (game_frozen) w_state_next = SCHED_FROZEN;
            end
            SCHED_FROZEN: begin
                if (game_start) w_state_next = SCHED_RUN;
            end
            default: w_state_next = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCHED_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level         <= '0;
            r_acc           <= '0;
            r_score_hi_prev <= 8'h00;
        end else if (game_start) begin
            r_level         <= '0;
            r_acc           <= '0;
            r_score_hi_prev <= 8'h00;
        end else begin
            if ((r_state == SCHED_RUN) && (score[15:8] != r_score_hi_prev)) begin
                r_score_hi_prev <= score[15:8];
                if (r_level < MAX_LEVEL) r_level <= r_level + 4'd1;
            end
            if (w_tick_fire) r_acc <= w_sum[ACC_W-1:0];
        end
    end

    step_burst u_burst (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_load       (w_tick_fire),
        .i_k          (w_k),
        .o_step_pulse (w_step)
    );

    assign step_pulse = w_step;
    assign busy       = w_step;
    assign level      = r_level;
    assign state      = r_state;

endmodule

// File: tb/tb_speed_scheduler.sv
// Self-checking bench for speed_scheduler: a small accumulator/level model
// queues expected burst lengths and accumulator values per tick.
module tb_speed_scheduler;

    logic        clk;
    logic        rst_n;
    logic        game_tick;
    logic        game_start;
    logic        game_frozen;
    logic [15:0] score;
    logic        step_pulse;
    logic        busy;
    logic [3:0]  level;
    logic [1:0]  state;

    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned m_acc;
    int unsigned m_level;
    int unsigned q_k[$];
    int unsigned q_acc[$];
    int unsigned pulse_total;

    speed_scheduler #(
        .ACC_W     (8),
        .BASE_INC  (10'd256),
        .INC_STEP  (10'd32),
        .MAX_LEVEL (4'd15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_tick   (game_tick),
        .game_start  (game_start),
        .game_frozen (game_frozen),
        .score       (score),
        .step_pulse  (step_pulse),
        .busy        (busy),
        .level       (level),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_tick();
        int unsigned sum;
        sum   = m_acc + 256 + m_level * 32;
        q_k.push_back(sum / 256);
        m_acc = sum % 256;
        q_acc.push_back(m_acc);
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic collect(input string name);
        logic [5:0]  pat;
        logic [5:0]  bpat;
        logic [5:0]  exp_pat;
        int unsigned k;
        int unsigned a;
        for (int i = 0; i < 6; i++) begin
            pat[i]  = step_pulse;
            bpat[i] = busy;
            @(negedge clk);
        end
        if (q_k.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            k = q_k.pop_front();
            a = q_acc.pop_front();
            exp_pat = 6'((1 << k) - 1);
            pulse_total += $countones(pat);
            n_checks++;
            if (pat !== exp_pat) $display("FAIL %s pulses: got %b expected %b", name, pat, exp_pat);
            else n_pass++;
            n_checks++;
            if (bpat !== exp_pat) $display("FAIL %s busy: got %b expected %b", name, bpat, exp_pat);
            else n_pass++;
            n_checks++;
            if (32'(dut.r_acc) !== a) $display("FAIL %s acc: got %0d expected %0d", name, dut.r_acc, a);
            else n_pass++;
        end
    endtask

    task automatic set_hundreds(input logic [7:0] hi);
        score[15:8] = hi;
        if (m_level < 15) m_level++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
        n_checks++;
        if (level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", level); else n_pass++;
        n_checks++;
        if (step_pulse !== 1'b0) $display("FAIL reset_step: got %b expected 0", step_pulse); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_level0();
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        m_acc = 0; m_level = 0;
        n_checks++;
        if (state !== 2'd1) $display("FAIL start_state: got %0d expected 1", state); else n_pass++;
        pulse_total = 0;
        for (int t = 0; t < 8; t++) begin
            drive_tick();
            collect("level0_tick");
        end
        n_checks++;
        if (pulse_total !== 8) $display("FAIL level0_total: got %0d expected 8", pulse_total); else n_pass++;
    endtask

    task automatic test_level1();
        set_hundreds(8'h01);
        n_checks++;
        if (level !== 4'd1) $display("FAIL level1: got %0d expected 1", level); else n_pass++;
        pulse_total = 0;
        for (int t = 0; t < 8; t++) begin
            drive_tick();
            collect("level1_tick");
        end
        n_checks++;
        if (pulse_total !== 9) $display("FAIL level1_total: got %0d expected 9", pulse_total); else n_pass++;
    endtask

    task automatic test_saturate();
        for (int n = 2; n <= 18; n++) begin
            set_hundreds(8'(((n / 10) << 4) | (n % 10)));
        end
        n_checks++;
        if (level !== 4'd15) $display("FAIL saturate_level: got %0d expected 15", level); else n_pass++;
        set_hundreds(8'h99);
        set_hundreds(8'h00);
        n_checks++;
        if (level !== 4'd15) $display("FAIL wrap_level: got %0d expected 15", level); else n_pass++;
        drive_tick();
        collect("sat_tick1");
        drive_tick();
        collect("sat_tick2");
    endtask

    task automatic test_frozen();
        int unsigned seen;
        int unsigned acc_hold;
        drive_tick();
        void'(q_k.pop_front());
        acc_hold = q_acc.pop_front();
        game_frozen = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (step_pulse) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1) $display("FAIL freeze_pulses: got %0d expected 1", seen); else n_pass++;
        n_checks++;
        if (dut.u_burst.r_pending !== 3'd0) $display("FAIL freeze_pending: got %0d expected 0", dut.u_burst.r_pending); else n_pass++;
        n_checks++;
        if (state !== 2'd2) $display("FAIL freeze_state: got %0d expected 2", state); else n_pass++;
        seen = 0;
        for (int t = 0; t < 2; t++) begin
            game_tick = 1'b1;
            @(negedge clk);
            game_tick = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (step_pulse) seen++;
                @(negedge clk);
            end
        end
        n_checks++;
        if (seen !== 0) $display("FAIL frozen_ticks: got %0d pulses expected 0", seen); else n_pass++;
        n_checks++;
        if (32'(dut.r_acc) !== acc_hold) $display("FAIL frozen_acc: got %0d expected %0d", dut.r_acc, acc_hold); else n_pass++;
    endtask

    task automatic test_start_priority();
        game_start = 1'b1;
        @(negedge clk);
        game_start  = 1'b0;
        game_frozen = 1'b0;
        m_acc = 0; m_level = 0;
        n_checks++;
        if (state !== 2'd1) $display("FAIL prio_state: got %0d expected 1", state); else n_pass++;
        n_checks++;
        if (level !== 4'd0) $display("FAIL prio_level: got %0d expected 0", level); else n_pass++;
        n_checks++;
        if (dut.r_acc !== 8'd0) $display("FAIL prio_acc: got %0d expected 0", dut.r_acc); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int unsigned seen;
        set_hundreds(8'h01);
        n_checks++;
        if (level !== 4'd1) $display("FAIL pre_reset_level: got %0d expected 1", level); else n_pass++;
        drive_tick();
        n_checks++;
        if (step_pulse !== 1'b1) $display("FAIL pre_reset_pulse: got %b expected 1", step_pulse); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (step_pulse !== 1'b0 || busy !== 1'b0) $display("FAIL async_reset_pulse: got %b/%b expected 0/0", step_pulse, busy); else n_pass++;
        n_checks++;
        if (level !== 4'd0) $display("FAIL async_reset_level: got %0d expected 0", level); else n_pass++;
        n_checks++;
        if (state !== 2'd0) $display("FAIL async_reset_state: got %0d expected 0", state); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        q_k.delete();
        q_acc.delete();
        seen = 0;
        for (int t = 0; t < 3; t++) begin
            game_tick = 1'b1;
            @(negedge clk);
            game_tick = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (step_pulse) seen++;
                @(negedge clk);
            end
        end
        n_checks++;
        if (seen !== 0) $display("FAIL idle_after_reset: got %0d pulses expected 0", seen); else n_pass++;
        n_checks++;
        if (state !== 2'd0) $display("FAIL idle_state: got %0d expected 0", state); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        m_acc = 0; m_level = 0; pulse_total = 0;
        rst_n = 1'b0; game_tick = 1'b0; game_start = 1'b0;
        game_frozen = 1'b0; score = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_level0();
        test_level1();
        test_saturate();
        test_frozen();
        test_start_priority();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
